// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Turns the UART receiver byte stream into validated game commands. Frames are
// four bytes [SYNC, CMD, ARG, CHK] and are accepted when CHK == CMD ^ ARG. A
// good frame produces a one-cycle cmd_valid with cmd_code/cmd_arg updated, a
// game_start pulse for START_CODE and a game_pause toggle for PAUSE_CODE. A bad
// checksum produces a one-cycle chk_err. All outputs are registered and appear
// the cycle after the CHK byte strobe.
//
// Optional feature (macro UART_CMD_TIMEOUT_EN): an inter-byte timer abandons a
// partial frame after TIMEOUT_CYCLES idle clocks and pulses timeout_err.
// Without the macro a partial frame waits indefinitely and timeout_err is 0.
//
// Ports
//   clk          in   1  system clock (100 MHz)
//   reset        in   1  synchronous, active-high reset
//   rx_data      in   8  received byte, valid while rx_valid=1
//   rx_valid     in   1  one-cycle strobe per received byte
//   cmd_valid    out  1  one-cycle strobe: new validated command
//   cmd_code     out  8  CMD of the last good frame
//   cmd_arg      out  8  ARG of the last good frame
//   game_start   out  1  one-cycle pulse with cmd_valid when CMD==START_CODE
//   game_pause   out  1  level, toggles on each good PAUSE_CODE frame
//   chk_err      out  1  one-cycle pulse on checksum mismatch
//   timeout_err  out  1  one-cycle pulse when a frame is abandoned on timeout
//   err_cnt      out  8  saturating count of chk_err + timeout_err events
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter logic [7:0]  START_CODE     = 8'h53,
  parameter logic [7:0]  PAUSE_CODE     = 8'h50,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       game_start,
  output logic       game_pause,
  output logic       chk_err,
  output logic       timeout_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    S_HUNT,
    S_GET_CMD,
    S_GET_ARG,
    S_GET_CHK
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cmd_lat_q, cmd_lat_d;
  logic [7:0] arg_lat_q, arg_lat_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_code_q, cmd_code_d;
  logic [7:0] cmd_arg_q, cmd_arg_d;
  logic       game_start_q, game_start_d;
  logic       game_pause_q, game_pause_d;
  logic       chk_err_q, chk_err_d;
  logic       timeout_err_q, timeout_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       tmo_fire;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Counts idle clocks while a frame is open; any byte restarts it and it
  // idles at 0 in HUNT. A byte arriving in the expiry cycle wins.
  always_comb begin
    timer_d  = '0;
    tmo_fire = 1'b0;
    if (state_q != S_HUNT && !rx_valid) begin
      if (timer_q == TMR_LAST) begin
        tmo_fire = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign tmo_fire = 1'b0;

  // TIMEOUT_CYCLES only sizes the timer; keep it referenced so both builds
  // share one parameter list.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d       = state_q;
    cmd_lat_d     = cmd_lat_q;
    arg_lat_d     = arg_lat_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    cmd_arg_d     = cmd_arg_q;
    game_start_d  = 1'b0;
    game_pause_d  = game_pause_q;
    chk_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    err_cnt_d     = err_cnt_q;

    if (rx_valid) begin
      case (state_q)
        S_HUNT: begin
          if (rx_data == SYNC_BYTE) state_d = S_GET_CMD;
        end
        // A SYNC byte here is plain data: no resynchronisation mid-frame.
        S_GET_CMD: begin
          cmd_lat_d = rx_data;
          state_d   = S_GET_ARG;
        end
        S_GET_ARG: begin
          arg_lat_d = rx_data;
          state_d   = S_GET_CHK;
        end
        S_GET_CHK: begin
          state_d = S_HUNT;
          if (rx_data == (cmd_lat_q ^ arg_lat_q)) begin
            cmd_valid_d  = 1'b1;
            cmd_code_d   = cmd_lat_q;
            cmd_arg_d    = arg_lat_q;
            game_start_d = (cmd_lat_q == START_CODE);
            if (cmd_lat_q == PAUSE_CODE) game_pause_d = ~game_pause_q;
          end else begin
            chk_err_d = 1'b1;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end else if (tmo_fire) begin
      state_d       = S_HUNT;
      timeout_err_d = 1'b1;
    end

    // The two error sources are mutually exclusive (one needs a byte, the
    // other needs its absence), so at most one increment per cycle.
    if ((chk_err_d || timeout_err_d) && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HUNT;
      cmd_lat_q     <= '0;
      arg_lat_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      cmd_arg_q     <= '0;
      game_start_q  <= 1'b0;
      game_pause_q  <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_lat_q     <= cmd_lat_d;
      arg_lat_q     <= arg_lat_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      cmd_arg_q     <= cmd_arg_d;
      game_start_q  <= game_start_d;
      game_pause_q  <= game_pause_d;
      chk_err_q     <= chk_err_d;
      timeout_err_q <= timeout_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_arg     = cmd_arg_q;
  assign game_start  = game_start_q;
  assign game_pause  = game_pause_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = timeout_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Drives byte streams into uart_cmd_parser and compares every output on every
// cycle against a frame-level reference model (a byte queue holding the open
// frame). A table of hand-written frames with expected outputs, a few directed
// sequences (reset mid-frame, timeout, saturation) and a randomized frame mix
// are applied. Build with or without UART_CMD_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 16;
`ifdef UART_CMD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       game_start;
  logic       game_pause;
  logic       chk_err;
  logic       timeout_err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .SYNC_BYTE     (8'hAA),
    .START_CODE    (8'h53),
    .PAUSE_CODE    (8'h50),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_arg    (cmd_arg),
    .game_start (game_start),
    .game_pause (game_pause),
    .chk_err    (chk_err),
    .timeout_err(timeout_err),
    .err_cnt    (err_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: open frame as a byte queue plus the visible output state.
  logic [7:0] m_frame[$];
  logic [7:0] m_code, m_arg, m_err;
  logic       m_pause, m_valid, m_start, m_chk, m_tmo;
  int         m_idle;

  task automatic model_reset();
    m_frame.delete();
    m_code = 8'h00; m_arg = 8'h00; m_err = 8'h00; m_pause = 1'b0;
    m_valid = 1'b0; m_start = 1'b0; m_chk = 1'b0; m_tmo = 1'b0;
    m_idle = 0;
  endtask

  task automatic model_err();
    if (m_err != 8'd255) m_err = m_err + 8'd1;
  endtask

  // Outputs expected after the clock edge that consumes (v, b).
  task automatic model_cycle(input logic v, input logic [7:0] b);
    m_valid = 1'b0; m_start = 1'b0; m_chk = 1'b0; m_tmo = 1'b0;
    if (v) begin
      m_idle = 0;
      if (m_frame.size() == 0) begin
        if (b == 8'hAA) m_frame.push_back(b);
      end else begin
        m_frame.push_back(b);
        if (m_frame.size() == 4) begin
          if ((m_frame[1] ^ m_frame[2]) == m_frame[3]) begin
            m_valid = 1'b1;
            m_code  = m_frame[1];
            m_arg   = m_frame[2];
            m_start = (m_frame[1] == 8'h53);
            if (m_frame[1] == 8'h50) m_pause = ~m_pause;
          end else begin
            m_chk = 1'b1;
            model_err();
          end
          m_frame.delete();
        end
      end
    end else if (TMO_EN && m_frame.size() != 0) begin
      m_idle++;
      if (m_idle == int'(TMO)) begin
        m_tmo = 1'b1;
        m_frame.delete();
        m_idle = 0;
        model_err();
      end
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk8("cmd_valid",   {7'b0, cmd_valid},   {7'b0, m_valid});
    chk8("cmd_code",    cmd_code,            m_code);
    chk8("cmd_arg",     cmd_arg,             m_arg);
    chk8("game_start",  {7'b0, game_start},  {7'b0, m_start});
    chk8("game_pause",  {7'b0, game_pause},  {7'b0, m_pause});
    chk8("chk_err",     {7'b0, chk_err},     {7'b0, m_chk});
    chk8("timeout_err", {7'b0, timeout_err}, {7'b0, m_tmo});
    chk8("err_cnt",     err_cnt,             m_err);
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    model_cycle(v, b);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    step(1'b1, 8'hAA);
    step(1'b1, c);
    step(1'b1, a);
    step(1'b1, k);
  endtask

  typedef struct {
    logic [7:0] b[6];
    int         n;
    logic       exp_valid;
    logic [7:0] exp_code;
    logic [7:0] exp_arg;
    logic       exp_start;
    logic       exp_pause;
    logic       exp_chk;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vt[5];

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();

    vt[0] = '{b: '{8'hAA, 8'h53, 8'h00, 8'h53, 8'h00, 8'h00}, n: 4, exp_valid: 1'b1,
              exp_code: 8'h53, exp_arg: 8'h00, exp_start: 1'b1, exp_pause: 1'b0,
              exp_chk: 1'b0, exp_err: 8'd0};
    vt[1] = '{b: '{8'hAA, 8'h10, 8'h20, 8'h31, 8'h00, 8'h00}, n: 4, exp_valid: 1'b0,
              exp_code: 8'h53, exp_arg: 8'h00, exp_start: 1'b0, exp_pause: 1'b0,
              exp_chk: 1'b1, exp_err: 8'd1};
    vt[2] = '{b: '{8'h12, 8'h34, 8'hAA, 8'h50, 8'h01, 8'h51}, n: 6, exp_valid: 1'b1,
              exp_code: 8'h50, exp_arg: 8'h01, exp_start: 1'b0, exp_pause: 1'b1,
              exp_chk: 1'b0, exp_err: 8'd1};
    vt[3] = '{b: '{8'hAA, 8'h50, 8'h01, 8'h51, 8'h00, 8'h00}, n: 4, exp_valid: 1'b1,
              exp_code: 8'h50, exp_arg: 8'h01, exp_start: 1'b0, exp_pause: 1'b0,
              exp_chk: 1'b0, exp_err: 8'd1};
    vt[4] = '{b: '{8'hAA, 8'hAA, 8'h07, 8'hAD, 8'h00, 8'h00}, n: 4, exp_valid: 1'b1,
              exp_code: 8'hAA, exp_arg: 8'h07, exp_start: 1'b0, exp_pause: 1'b0,
              exp_chk: 1'b0, exp_err: 8'd1};

    rst_cycle();
    rst_cycle();

    // Table-driven frames, checked right after the last byte's edge.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vt[i].n; j++) step(1'b1, vt[i].b[j]);
      chk8("tbl_valid", {7'b0, cmd_valid},  {7'b0, vt[i].exp_valid});
      chk8("tbl_code",  cmd_code,           vt[i].exp_code);
      chk8("tbl_arg",   cmd_arg,            vt[i].exp_arg);
      chk8("tbl_start", {7'b0, game_start}, {7'b0, vt[i].exp_start});
      chk8("tbl_pause", {7'b0, game_pause}, {7'b0, vt[i].exp_pause});
      chk8("tbl_chk",   {7'b0, chk_err},    {7'b0, vt[i].exp_chk});
      chk8("tbl_err",   err_cnt,            vt[i].exp_err);
      step(1'b0, 8'h00);
      chk8("tbl_pulse_end", {7'b0, cmd_valid | chk_err | game_start}, 8'h00);
    end

    // Reset mid-frame, then a full good frame.
    step(1'b1, 8'hAA);
    step(1'b1, 8'h53);
    rst_cycle();
    chk8("rst_err_cnt", err_cnt, 8'h00);
    chk8("rst_code", cmd_code, 8'h00);
    send_frame(8'h53, 8'h00, 8'h53);
    chk8("rst_then_valid", {7'b0, cmd_valid}, 8'h01);
    chk8("rst_then_start", {7'b0, game_start}, 8'h01);

    // Inter-byte timeout: partial frame, TMO idle cycles, then a good frame.
    step(1'b1, 8'hAA);
    step(1'b1, 8'h53);
    for (int k = 0; k < int'(TMO); k++) step(1'b0, 8'h00);
    chk8("tmo_pulse", {7'b0, timeout_err}, {7'b0, TMO_EN});
    step(1'b0, 8'h00);
    chk8("tmo_pulse_end", {7'b0, timeout_err}, 8'h00);
    send_frame(8'h53, 8'h00, 8'h53);
    chk8("tmo_then_valid", {7'b0, cmd_valid}, {7'b0, TMO_EN});

    // Byte arriving exactly in the expiry cycle keeps the frame alive.
    step(1'b1, 8'hAA);
    for (int k = 0; k < int'(TMO) - 1; k++) step(1'b0, 8'h00);
    step(1'b1, 8'h50);
    step(1'b1, 8'h02);
    step(1'b1, 8'h52);
    chk8("expiry_byte_valid", {7'b0, cmd_valid}, {7'b0, ~TMO_EN | 1'b1});

    // Randomized frame mix with idle gaps, checked by the model every cycle.
    for (int f = 0; f < 300; f++) begin
      int unsigned r;
      logic [7:0]  c, a;
      r = $urandom % 8;
      if ($urandom % 4 == 0) begin
        int unsigned gap;
        gap = $urandom_range(0, TMO + 3);
        for (int g = 0; g < int'(gap); g++) step(1'b0, 8'h00);
      end
      case ($urandom % 3)
        0:       c = 8'h53;
        1:       c = 8'h50;
        default: c = 8'($urandom);
      endcase
      a = 8'($urandom);
      if (r == 0) begin
        step(1'b1, 8'($urandom));
      end else if (r == 1) begin
        step(1'b1, 8'hAA);
        step(1'b1, c);
      end else if (r == 2) begin
        send_frame(c, a, (c ^ a) ^ 8'(1 << $urandom_range(0, 7)));
      end else begin
        send_frame(c, a, c ^ a);
      end
    end

    // Saturation: set pause, then 260 back-to-back bad frames.
    rst_cycle();
    send_frame(8'h50, 8'h00, 8'h50);
    for (int f = 0; f < 260; f++) send_frame(8'h10, 8'h20, 8'h31);
    chk8("sat_err_cnt", err_cnt, 8'd255);
    chk8("sat_pause", {7'b0, game_pause}, 8'h01);
    send_frame(8'h53, 8'h00, 8'h53);
    chk8("sat_good_valid", {7'b0, cmd_valid}, 8'h01);
    chk8("sat_hold", err_cnt, 8'd255);
    step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
